mem_fill_arbiter: RTL and testbench
===================================

MEM_FILL_ARBITER -- requirements
Module: mem_fill_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4: cycles from a read issue to its mem_rvalid.
REQ-002 SHALL have parameter WORDS, default 8: 16-bit words per 16-byte cache block.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have ports i_req (input, 1 bit) and i_addr (input, 16 bits): I-cache miss request and miss address, both held until i_done.
REQ-006 SHALL have ports d_req (input, 1), d_wr (input, 1), d_addr (input, 16) and d_wdata (input, 16): D-cache request; d_wr=1 means single-word write-through, d_wr=0 means block fill.
REQ-007 SHALL have ports i_grant and d_grant (outputs, 1 bit each): requester owns memory.
REQ-008 SHALL have ports i_data_valid and d_data_valid (outputs, 1 bit each): fill_data carries a word for that requester.
REQ-009 SHALL have ports fill_word (output, 3 bits) and fill_data (output, 16 bits): index and value of the returned word.
REQ-010 SHALL have ports i_done and d_done (outputs, 1 bit each): one-cycle transaction-complete pulse.
REQ-011 SHALL have memory-side outputs mem_en (1), mem_wr (1), mem_addr (16) and mem_wdata (16).
REQ-012 SHALL have memory-side inputs mem_rdata (16) and mem_rvalid (1).

Function
REQ-013 States SHALL be IDLE, FILL, WRITE and DONE.
REQ-014 Requests SHALL be sampled only in IDLE.
REQ-015 With one request pending, IDLE SHALL go to FILL (read request) or WRITE (d_req with d_wr=1) and assert that requester's grant from the next cycle.
REQ-016 With both requests pending, the requester not served last SHALL win; after reset D SHALL win.
REQ-017 The grant SHALL stay high from FILL/WRITE entry through DONE.
REQ-018 FILL SHALL issue WORDS reads on consecutive cycles: mem_en=1, mem_wr=0, mem_addr={addr[15:4],4'b0}+2*k for k=0..WORDS-1, with no gaps.
REQ-019 Return counter: each mem_rvalid in FILL SHALL drive fill_data=mem_rdata, fill_word=counter and the granted requester's data_valid in the same cycle, then increment the counter.
REQ-020 Issue and return counters SHALL be independent; returns may overlap later issues.
REQ-021 The done pulse SHALL coincide with the WORDS-th data_valid; the next state is DONE.
REQ-022 Nominal fill SHALL span WORDS+MEM_LATENCY cycles from the first issue through the last data_valid.
REQ-023 WRITE SHALL last exactly one cycle with mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata and d_done=1; the next state is DONE.
REQ-024 DONE SHALL last one cycle, drop the grant, ignore requests, then go to IDLE; a requester still holding req in IDLE starts a new transaction.
REQ-025 mem_rvalid outside FILL SHALL be ignored: no data_valid, counters unchanged.
REQ-026 Request deassertion mid-transaction SHALL be ignored; the transaction completes.
REQ-027 When idle, mem_en=0, mem_wr=0, and mem_addr, mem_wdata, fill_data and fill_word SHALL be 0.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, clear both counters, set the last-served record to I (so D wins next), and drive every output to 0.
REQ-029 Reset mid-FILL or mid-WRITE SHALL abort the transaction; in-flight mem_rvalid after reset SHALL be ignored per REQ-025.

Structure
REQ-030 State encoding, WORDS and the block-offset width SHALL live in shared package mem_pkg, reused by the cache fill logic.
REQ-031 No sub-module is required; an optional mem_fill_counter (issue/return counter pair) is permitted.

Verification
REQ-032 I-only fill at i_addr=0x1236 SHALL give reads at 0x1230..0x123E, 8 i_data_valid with fill_word 0..7, and i_done with the 8th word, 12 cycles after the first issue.
REQ-033 i_req and d_req (read) raised in the same cycle after reset SHALL serve D first, then I starting after D's DONE cycle.
REQ-034 D write d_addr=0x4002, d_wdata=0xBEEF SHALL give one cycle of mem_en=1, mem_wr=1, mem_addr=0x4002, mem_wdata=0xBEEF, with d_done=1 in that cycle.
REQ-035 Two back-to-back D fills with I pending SHALL serve D, then I, then D (alternation).
REQ-036 rst_n low after the 3rd returned word, with 5 more mem_rvalid pulses following, SHALL give all outputs 0 and no data_valid or done.
REQ-037 A stray mem_rvalid in IDLE SHALL produce no data_valid, and the next fill SHALL still start at fill_word 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the cache block-fill path: state encoding,
// block geometry and the block-base address helper.
package mem_pkg;

  localparam int unsigned FILL_WORDS   = 8;  // 16-bit words per 16-byte block
  localparam int unsigned BLK_OFFSET_W = 4;  // byte-offset bits inside a block
  localparam int unsigned WORD_IDX_W   = 3;  // word index bits inside a block

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } fill_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  function automatic logic [15:0] block_base(input logic [15:0] addr);
    return {addr[15:BLK_OFFSET_W], {BLK_OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_fill_counter.sv
// Issue/return counter pair for a block fill. The two counters advance
// independently so that returns can overlap later issues.
module mem_fill_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          issue_inc,
  input  logic          ret_inc,
  output logic [CW-1:0] issue_cnt,
  output logic [CW-1:0] ret_cnt
);

  // Issue counter: one step per read request sent to memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
    end else if (clear) begin
      issue_cnt <= '0;
    end else if (issue_inc) begin
      issue_cnt <= issue_cnt + CW'(1);
    end
  end

  // Return counter: one step per accepted read return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_cnt <= '0;
    end else if (clear) begin
      ret_cnt <= '0;
    end else if (ret_inc) begin
      ret_cnt <= ret_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates one memory port between I-cache block fills and D-cache
// block fills / single-word write-through.
//
//   state | meaning
//   IDLE  | no owner; requests sampled here, outputs quiet
//   FILL  | issuing block reads and collecting returns for the owner
//   WRITE | single-cycle D write-through
//   DONE  | one-cycle cool-down, grant still held, requests ignored
module mem_fill_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned WORDS       = mem_pkg::FILL_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        i_grant,
  output logic        d_grant,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        i_done,
  output logic        d_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int unsigned CW = $clog2(WORDS + 1);

  fill_state_e   state, state_nxt;
  owner_e        owner, owner_nxt;
  owner_e        last_served, last_nxt;
  logic [15:0]   base_addr, base_nxt;
  logic [15:0]   wdata_q, wdata_nxt;
  logic [CW-1:0] issue_cnt, ret_cnt;
  logic          issuing, ret_hit, last_ret, pick_d;

  assign issuing  = (state == FILL) && (issue_cnt < CW'(WORDS));
  assign ret_hit  = (state == FILL) && mem_rvalid;
  assign last_ret = ret_hit && (ret_cnt == CW'(WORDS - 1));
  // D wins a tie unless it was the one served last.
  assign pick_d   = d_req && (!i_req || (last_served == OWNER_I));

  mem_fill_counter #(.CW(CW)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state != FILL),
    .issue_inc (issuing),
    .ret_inc   (ret_hit),
    .issue_cnt (issue_cnt),
    .ret_cnt   (ret_cnt)
  );

  // State, owner and latched transaction parameters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWNER_I;
      last_served <= OWNER_I;
      base_addr   <= '0;
      wdata_q     <= '0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_served <= last_nxt;
      base_addr   <= base_nxt;
      wdata_q     <= wdata_nxt;
    end
  end

  // Next-state: arbitration in IDLE, completion tracking elsewhere.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_served;
    base_nxt  = base_addr;
    wdata_nxt = wdata_q;
    case (state)
      IDLE: begin
        if (pick_d) begin
          owner_nxt = OWNER_D;
          last_nxt  = OWNER_D;
          wdata_nxt = d_wdata;
          if (d_wr) begin
            base_nxt  = d_addr;
            state_nxt = WRITE;
          end else begin
            base_nxt  = block_base(d_addr);
            state_nxt = FILL;
          end
        end else if (i_req) begin
          owner_nxt = OWNER_I;
          last_nxt  = OWNER_I;
          base_nxt  = block_base(i_addr);
          wdata_nxt = '0;
          state_nxt = FILL;
        end
      end
      FILL:    if (last_ret) state_nxt = DONE;
      WRITE:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: everything quiet unless the state says otherwise.
  always_comb begin
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    fill_word    = '0;
    fill_data    = '0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (state != IDLE) begin
      i_grant = (owner == OWNER_I);
      d_grant = (owner == OWNER_D);
    end
    case (state)
      FILL: begin
        if (issuing) begin
          mem_en   = 1'b1;
          mem_addr = base_addr + 16'({issue_cnt, 1'b0});
        end
        if (ret_hit) begin
          fill_data    = mem_rdata;
          fill_word    = ret_cnt[WORD_IDX_W-1:0];
          i_data_valid = (owner == OWNER_I);
          d_data_valid = (owner == OWNER_D);
          i_done       = last_ret && (owner == OWNER_I);
          d_done       = last_ret && (owner == OWNER_D);
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = base_addr;
        mem_wdata = wdata_q;
        d_done    = 1'b1;
      end
      default: ;
    endcase
  end

  // A return can only follow a read issued MEM_LATENCY cycles earlier.
  logic [31:0] ret_plus_lat;
  assign ret_plus_lat = 32'(ret_cnt) + MEM_LATENCY;

  a_ret_after_issue: assert property (@(posedge clk) disable iff (!rst_n)
    ret_hit |-> (32'(issue_cnt) >= ((ret_plus_lat < WORDS) ? ret_plus_lat : WORDS)));

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: fixed-latency memory model, scoreboard
// queues for grants, reads, writes and returned words, a vector table for
// single transactions and hand-written arbitration/reset sequences.
module tb_mem_fill_arbiter;

  localparam int L     = 4;
  localparam int WORDS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_grant, d_grant, i_data_valid, d_data_valid;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        i_done, d_done, mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;

  logic        stray_v = 1'b0;
  logic [15:0] stray_d = '0;

  mem_fill_arbiter #(.MEM_LATENCY(L), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_grant(i_grant), .d_grant(d_grant),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .fill_word(fill_word), .fill_data(fill_data),
    .i_done(i_done), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Memory: every read returns exactly L cycles after issue.
  logic [L-1:0] pv = '0;
  logic [15:0]  pa [L];
  always @(posedge clk) begin
    pv    <= {pv[L-2:0], mem_en & ~mem_wr};
    pa[0] <= mem_addr;
    for (int i = 1; i < L; i++) pa[i] <= pa[i-1];
  end
  assign mem_rvalid = pv[L-1] | stray_v;
  assign mem_rdata  = pv[L-1] ? mem_fn(pa[L-1]) : stray_d;

  logic [58:0] all_out;
  assign all_out = {i_grant, d_grant, mem_en, mem_wr, mem_addr, mem_wdata,
                    fill_data, fill_word, i_data_valid, d_data_valid, i_done, d_done};

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic        is_d;
    logic [2:0]  word;
    logic [15:0] data;
  } ret_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        own_q [$];
  logic [15:0] iss_q [$];
  ret_t        ret_q [$];
  wr_t         wr_q  [$];

  task automatic push_txn(input logic side_d, input logic wr, input logic [15:0] base,
                          input logic [15:0] wdata);
    logic [15:0] a;
    ret_t r;
    wr_t  w;
    own_q.push_back(side_d);
    if (wr) begin
      w.addr = base;
      w.data = wdata;
      wr_q.push_back(w);
    end else begin
      for (int k = 0; k < WORDS; k++) begin
        a      = base + 16'(2 * k);
        r.is_d = side_d;
        r.word = 3'(k);
        r.data = mem_fn(a);
        iss_q.push_back(a);
        ret_q.push_back(r);
      end
    end
  endtask

  task automatic clear_queues();
    own_q.delete();
    iss_q.delete();
    ret_q.delete();
    wr_q.delete();
  endtask

  // Monitor: compare DUT activity against the scoreboard each cycle.
  logic prev_g = 1'b0;
  always @(negedge clk) begin
    logic any_g;
    logic exp_d;
    logic [15:0] ea;
    ret_t r;
    wr_t  w;
    if (!rst_n) begin
      prev_g = 1'b0;
    end else begin
      any_g = i_grant | d_grant;
      check("grant_onehot", {i_grant, d_grant} == 2'b11, 0);
      if (any_g && !prev_g) begin
        check("grant_expected", own_q.size() > 0, 1);
        if (own_q.size() > 0) begin
          exp_d = own_q.pop_front();
          check("grant_owner", {i_grant, d_grant}, exp_d ? 2'b01 : 2'b10);
        end
      end
      prev_g = any_g;
      if (!any_g) check("idle_quiet", all_out, 0);
      if (mem_en && !mem_wr) begin
        check("read_expected", iss_q.size() > 0, 1);
        if (iss_q.size() > 0) begin
          ea = iss_q.pop_front();
          check("read_addr", mem_addr, ea);
        end
      end
      if (mem_en && mem_wr) begin
        check("write_expected", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          check("write_addr", mem_addr, w.addr);
          check("write_data", mem_wdata, w.data);
          check("write_done", {i_done, d_done, d_grant}, 3'b011);
        end
      end
      if (i_data_valid || d_data_valid) begin
        check("ret_expected", ret_q.size() > 0, 1);
        if (ret_q.size() > 0) begin
          r = ret_q.pop_front();
          check("ret_side", {i_data_valid, d_data_valid}, r.is_d ? 2'b01 : 2'b10);
          check("ret_grant", {i_grant, d_grant}, r.is_d ? 2'b01 : 2'b10);
          check("fill_word", fill_word, r.word);
          check("fill_data", fill_data, r.data);
          check("fill_done", {i_done, d_done},
                (r.word == 3'(WORDS - 1)) ? (r.is_d ? 2'b01 : 2'b10) : 2'b00);
        end
      end
      if ((i_done || d_done) && !(i_data_valid || d_data_valid) && !(mem_en && mem_wr))
        check("done_context", {i_done, d_done}, 0);
    end
  end

  typedef struct {
    logic        side_d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_base;
    int          exp_span;
    logic        drop_early;
  } vec_t;

  task automatic drop_reqs();
    i_req = 1'b0;
    d_req = 1'b0;
    d_wr  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic got;
    int   g_cyc;
    push_txn(v.side_d, v.wr, v.exp_base, v.wdata);
    @(negedge clk);
    if (v.side_d) begin
      d_req = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    @(negedge clk);
    check($sformatf("vec%0d_grant", idx), {i_grant, d_grant}, v.side_d ? 2'b01 : 2'b10);
    g_cyc = cyc;
    if (v.drop_early) drop_reqs();
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (i_done || d_done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("vec%0d_done_seen", idx), got, 1);
    if (got) begin
      check($sformatf("vec%0d_done_side", idx), {i_done, d_done}, v.side_d ? 2'b01 : 2'b10);
      check($sformatf("vec%0d_span", idx), cyc - g_cyc + 1, v.exp_span);
    end
    drop_reqs();
    repeat (3) @(negedge clk);
    check($sformatf("vec%0d_drained", idx), own_q.size() + iss_q.size() + ret_q.size() + wr_q.size(), 0);
  endtask

  task automatic wait_for(input int sel, input int budget, input string name, output int hit_cyc);
    logic hit;
    hit     = 1'b0;
    hit_cyc = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      case (sel)
        0:       hit = d_done;
        1:       hit = i_done;
        default: hit = i_grant;
      endcase
      if (hit) begin
        hit_cyc = cyc;
        break;
      end
    end
    check(name, hit, 1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drop_reqs();
    stray_v = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_out, 0);
    clear_queues();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  vec_t vecs [7];

  initial begin
    int dc, ic, gc, nd, ni, nret;
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, 16'h1236, 16'h0000, 16'h1230, WORDS + L, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'hABCF, 16'h0000, 16'hABC0, WORDS + L, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'h4002, 16'hBEEF, 16'h4002, 1,         1'b0};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'hFFF0, WORDS + L, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, WORDS + L, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 1,         1'b1};
    vecs[6] = '{1'b0, 1'b0, 16'h8ACE, 16'h0000, 16'h8AC0, WORDS + L, 1'b1};

    reset_dut();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Simultaneous requests right after reset: D first, I after D's DONE.
    reset_dut();
    push_txn(1'b1, 1'b0, 16'h5550, 16'h0);
    push_txn(1'b0, 1'b0, 16'h6660, 16'h0);
    i_req = 1'b1; i_addr = 16'h6662;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h555A;
    wait_for(0, 40, "tie_d_done", dc);
    d_req = 1'b0;
    wait_for(2, 10, "tie_i_grant", gc);
    check("tie_i_start_after_done", gc - dc, 3);
    wait_for(1, 40, "tie_i_done", ic);
    i_req = 1'b0;
    repeat (3) @(negedge clk);
    check("tie_drained", own_q.size() + iss_q.size() + ret_q.size(), 0);

    // Back-to-back D fills with I pending: D, I, D.
    push_txn(1'b1, 1'b0, 16'h2460, 16'h0);
    push_txn(1'b0, 1'b0, 16'h8000, 16'h0);
    push_txn(1'b1, 1'b0, 16'h2460, 16'h0);
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2468;
    i_req = 1'b1; i_addr = 16'h8001;
    nd = 0;
    ni = 0;
    for (int n = 0; n < 150 && (nd < 2 || ni < 1); n++) begin
      @(negedge clk);
      if (d_done) begin
        nd++;
        if (nd == 2) d_req = 1'b0;
      end
      if (i_done) begin
        ni++;
        i_req = 1'b0;
      end
    end
    check("alt_d_dones", nd, 2);
    check("alt_i_dones", ni, 1);
    drop_reqs();
    repeat (3) @(negedge clk);
    check("alt_drained", own_q.size() + iss_q.size() + ret_q.size(), 0);

    // Reset after the third returned word, then more returns arrive.
    push_txn(1'b0, 1'b0, 16'h3000, 16'h0);
    i_req = 1'b1; i_addr = 16'h3004;
    nret = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (i_data_valid) nret++;
      if (nret == 3) break;
    end
    check("abort_third_word", nret, 3);
    #1;
    rst_n = 1'b0;
    i_req = 1'b0;
    #1;
    check("abort_outputs_zero", all_out, 0);
    clear_queues();
    @(negedge clk);
    rst_n = 1'b1;
    stray_d = 16'h1357;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("abort_quiet", all_out, 0);
      stray_v = (k % 2 == 0);
    end
    stray_v = 1'b0;
    repeat (6) @(negedge clk);

    // Stray return in IDLE, then a fill that must start at word 0.
    stray_d = 16'h7777;
    stray_v = 1'b1;
    #1;
    check("stray_no_valid", {i_data_valid, d_data_valid, fill_data}, 0);
    @(negedge clk);
    stray_v = 1'b0;
    v = '{1'b0, 1'b0, 16'h0C0C, 16'h0000, 16'h0C00, WORDS + L, 1'b0};
    run_vec(v, 7);

    check("final_drained", own_q.size() + iss_q.size() + ret_q.size() + wr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
